// File: rtl/tof_pkg.sv
// Shared types and tap decode for the ToF TDC capture block.
// Fine decode: leading-ones by default, popcount when TOF_TDC_BUBBLE_FIX_EN is defined.
package tof_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_COUNTING
    } state_e;

    localparam int TAP_W      = 8;
    localparam int FINE_W     = 4;
    localparam int FINE_LSB   = 0;
    localparam int COARSE_LSB = FINE_LSB + FINE_W;

    function automatic logic [FINE_W-1:0] thermo_to_fine(input logic [TAP_W-1:0] taps);
        logic [FINE_W-1:0] n;
`ifdef TOF_TDC_BUBBLE_FIX_EN
        // Counting every set tap absorbs isolated metastability bubbles.
        n = '0;
        for (int i = 0; i < TAP_W; i++) begin
            n = n + {{(FINE_W-1){1'b0}}, taps[i]};
        end
`else
        logic run;
        n   = '0;
        run = 1'b1;
        for (int i = 0; i < TAP_W; i++) begin
            run = run & taps[i];
            n   = n + {{(FINE_W-1){1'b0}}, run};
        end
`endif
        return n;
    endfunction

endpackage

// File: rtl/tof_tdc_capture_if.sv
// Result stream from the TDC capture block to the CPU-side bus bridge.
interface tof_result_if #(
    parameter int PAYLOAD_W = 21
);
    logic                 io_result_valid;
    logic                 io_result_ready;
    logic [PAYLOAD_W-1:0] io_result_payload;

    modport master (
        output io_result_valid,
        output io_result_payload,
        input  io_result_ready
    );

    modport slave (
        input  io_result_valid,
        input  io_result_payload,
        output io_result_ready
    );
endinterface

// File: rtl/tof_result_fifo.sv
// Registered result FIFO with valid/ready pop; a push while full and not popping is dropped.
module tof_result_fifo #(
    parameter int WIDTH = 21,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             ready_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] head_o,
    output logic             drop_o
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;

    logic empty, full, pop, wr_en;

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));
    assign pop   = ready_i && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign wr_en  = push_i && (!full || pop);
    assign drop_o = push_i && full && !pop;

    assign valid_o = !empty;
    assign head_o  = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)   rd_ptr_d = rd_ptr_q + 1'b1;
        if (wr_en && !pop)      count_d = count_q + 1'b1;
        else if (!wr_en && pop) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/tof_tdc_capture.sv
// ToF TDC capture: arm/start/stop FSM, coarse counter, tap decode and result FIFO.
// Optional macro TOF_TDC_BUBBLE_FIX_EN selects the bubble-tolerant fine decode.
module tof_tdc_capture
    import tof_pkg::*;
#(
    parameter int COARSE_W       = 16,
    parameter int TIMEOUT_CYCLES = 4000,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic             io_mainClk,
    input  logic             io_reset,
    input  logic             io_arm,
    input  logic             io_continuous,
    input  logic             io_clear,
    input  logic             io_start,
    input  logic             io_stop,
    input  logic [TAP_W-1:0] io_taps,
    tof_result_if.master     res,
    output logic             io_busy,
    output logic             io_overflow
);
    localparam int PAYLOAD_W = COARSE_W + 1 + FINE_W;
    localparam logic [COARSE_W-1:0] TIMEOUT_C = COARSE_W'(TIMEOUT_CYCLES);

    state_e                state_q, state_d;
    logic [COARSE_W-1:0]   cnt_q,   cnt_d;
    logic                  ovf_q,   ovf_d;
    logic                  push;
    logic [PAYLOAD_W-1:0]  push_data;
    logic [FINE_W-1:0]     fine;
    logic                  drop;

    assign fine = thermo_to_fine(io_taps);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        push      = 1'b0;
        push_data = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (io_arm) state_d = ST_ARMED;
            end
            ST_ARMED: begin
                // A stop coincident with start is deliberately ignored.
                if (io_start) begin
                    state_d = ST_COUNTING;
                    cnt_d   = COARSE_W'(1);
                end
            end
            ST_COUNTING: begin
                if (io_stop) begin
                    push      = 1'b1;
                    push_data = {1'b0, cnt_q, fine};
                    state_d   = io_continuous ? ST_ARMED : ST_IDLE;
                    cnt_d     = '0;
                end else if (cnt_q == TIMEOUT_C) begin
                    push      = 1'b1;
                    push_data = {1'b1, TIMEOUT_C, {FINE_W{1'b0}}};
                    state_d   = io_continuous ? ST_ARMED : ST_IDLE;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A drop in the same cycle as a clear keeps the flag set.
    always_comb begin
        ovf_d = ovf_q;
        if (drop)          ovf_d = 1'b1;
        else if (io_clear) ovf_d = 1'b0;
    end

    always_ff @(posedge io_mainClk) begin
        if (io_reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    assign io_busy     = (state_q == ST_ARMED) || (state_q == ST_COUNTING);
    assign io_overflow = ovf_q;

    tof_result_fifo #(
        .WIDTH (PAYLOAD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (io_mainClk),
        .rst_i       (io_reset),
        .push_i      (push),
        .push_data_i (push_data),
        .ready_i     (res.io_result_ready),
        .valid_o     (res.io_result_valid),
        .head_o      (res.io_result_payload),
        .drop_o      (drop)
    );

endmodule

// File: tb/tb_tof_tdc_capture.sv
// Scoreboard bench for tof_tdc_capture: stimulus predicts entries, a monitor pops and compares.
module tb_tof_tdc_capture;
    localparam int TMO   = 20;
    localparam int DEPTH = 4;
    localparam int CW    = 16;
`ifdef TOF_TDC_BUBBLE_FIX_EN
    localparam logic [3:0] FINE_0B = 4'd3;
`else
    localparam logic [3:0] FINE_0B = 4'd2;
`endif

    typedef logic [CW+4:0] pl_t;

    logic       clk = 1'b0;
    logic       rst, arm, cont, clr, start, stop;
    logic [7:0] taps;
    logic       busy, ovf;

    tof_result_if #(.PAYLOAD_W(CW + 5)) rif ();

    tof_tdc_capture #(
        .COARSE_W       (CW),
        .TIMEOUT_CYCLES (TMO),
        .FIFO_DEPTH     (DEPTH)
    ) dut (
        .io_mainClk    (clk),
        .io_reset      (rst),
        .io_arm        (arm),
        .io_continuous (cont),
        .io_clear      (clr),
        .io_start      (start),
        .io_stop       (stop),
        .io_taps       (taps),
        .res           (rif),
        .io_busy       (busy),
        .io_overflow   (ovf)
    );

    always #5 clk = ~clk;

    pl_t sb[$];
    int  total = 0;
    int  bad   = 0;
    bit  exp_ovf  = 1'b0;
    bit  armed    = 1'b0;
    bit  rand_rdy = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference fine value straight from the decode rules.
    function automatic logic [3:0] ref_fine(input logic [7:0] t);
`ifdef TOF_TDC_BUBBLE_FIX_EN
        return 4'($countones(t));
`else
        int n = 0;
        while (n < 8 && t[n]) n++;
        return 4'(n);
`endif
    endfunction

    // Monitor: pops the scoreboard on every accepted transfer and tracks the sticky flag.
    initial begin
        pl_t e;
        forever begin
            @(negedge clk);
            if (rif.io_result_valid && rif.io_result_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_entry", {11'd0, rif.io_result_payload}, 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    check("payload", {11'd0, rif.io_result_payload}, {11'd0, e});
                end
            end
            check("overflow", {31'd0, ovf}, {31'd0, exp_ovf});
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (rand_rdy) rif.io_result_ready = 1'($urandom_range(0, 1));
    endtask

    // Called just after the monitor's negedge in the push cycle: occupancy decides keep or drop.
    task automatic record(input int coarse, input logic [3:0] fine, input bit to);
        pl_t e;
        e = {to, 16'(coarse), fine};
        if (sb.size() < DEPTH) sb.push_back(e);
        else exp_ovf = 1'b1;
    endtask

    // stop_at > TMO means no stop, so the timeout entry is expected.
    task automatic measure(input int stop_at, input logic [7:0] t, input logic [3:0] efine,
                           input bit c, input bit stop_on_start, input bit rdy_at_push);
        bit push_now;
        if (!armed) begin
            arm = 1'b1;
            step();
            arm = 1'b0;
        end
        cont  = c;
        start = 1'b1;
        stop  = stop_on_start;
        taps  = 8'($urandom);
        step();
        start = 1'b0;
        stop  = 1'b0;
        for (int k = 1; k <= TMO; k++) begin
            push_now = (k == stop_at) || (k == TMO);
            start = push_now ? 1'b0 : 1'($urandom_range(0, 1));
            stop  = (k == stop_at);
            taps  = (k == stop_at) ? t : 8'($urandom);
            if (push_now && rdy_at_push) rif.io_result_ready = 1'b1;
            @(negedge clk);
            if (k == 1) check("busy_counting", {31'd0, busy}, 32'd1);
            #1;
            if (k == stop_at)  record(k, efine, 1'b0);
            else if (push_now) record(TMO, 4'd0, 1'b1);
            step();
            stop  = 1'b0;
            start = 1'b0;
            if (push_now) break;
        end
        if (rdy_at_push) rif.io_result_ready = 1'b0;
        @(negedge clk);
        check("busy_after_push", {31'd0, busy}, {31'd0, c});
        step();
        armed = c;
    endtask

    task automatic drain(input int expect_n);
        int n = 0;
        rif.io_result_ready = 1'b1;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (expect_n >= 0) check("drain_cycles", n, expect_n);
        else check("drain_bounded", {31'd0, n < 50}, 32'd1);
        step();
        rif.io_result_ready = 1'b0;
    endtask

    task automatic clear_ovf();
        clr = 1'b1;
        @(negedge clk);
        #1;
        exp_ovf = 1'b0;
        step();
        clr = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"},   {31'd0, rif.io_result_valid}, 32'd0);
        check({tag, "_payload"}, {11'd0, rif.io_result_payload}, 32'd0);
        check({tag, "_busy"},    {31'd0, busy}, 32'd0);
        check({tag, "_ovf"},     {31'd0, ovf}, 32'd0);
    endtask

    initial begin
        logic [7:0] t;
        rst = 1'b1; arm = 1'b0; cont = 1'b0; clr = 1'b0;
        start = 1'b0; stop = 1'b0; taps = 8'd0;
        rif.io_result_ready = 1'b0;
        repeat (3) step();
        @(negedge clk);
        check_reset_outputs("reset");
        step();
        rst = 1'b0;
        step();

        // Single shot: coarse 5, taps 0x07.
        rif.io_result_ready = 1'b1;
        measure(5, 8'h07, 4'd3, 1'b0, 1'b0, 1'b0);
        repeat (3) step();
        check("single_drained", sb.size(), 0);

        // Continuous, consumer stalled, then drained one per cycle (long gap bounded by the timeout).
        rif.io_result_ready = 1'b0;
        t = 8'($urandom); measure(1,  t, ref_fine(t), 1'b1, 1'b0, 1'b0);
        repeat ($urandom_range(0, 3)) step();
        t = 8'($urandom); measure(2,  t, ref_fine(t), 1'b1, 1'b0, 1'b0);
        repeat ($urandom_range(0, 3)) step();
        t = 8'($urandom); measure(19, t, ref_fine(t), 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("stalled_valid", {31'd0, rif.io_result_valid}, 32'd1);
        step();
        drain(3);

        // Timeout, then stop exactly on the timeout cycle.
        rif.io_result_ready = 1'b1;
        measure(TMO + 5, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0);
        measure(TMO, 8'h3F, 4'd6, 1'b0, 1'b0, 1'b0);
        repeat (2) step();

        // Overflow: five results into four slots, clear, then push while popping a full FIFO.
        rif.io_result_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            t = 8'($urandom);
            measure($urandom_range(1, 10), t, ref_fine(t), 1'b1, 1'b0, 1'b0);
        end
        @(negedge clk);
        check("ovf_set", {31'd0, ovf}, 32'd1);
        step();
        clear_ovf();
        @(negedge clk);
        check("ovf_cleared", {31'd0, ovf}, 32'd0);
        step();
        t = 8'($urandom);
        measure($urandom_range(1, 10), t, ref_fine(t), 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        check("ovf_not_set_on_pop", {31'd0, ovf}, 32'd0);
        step();
        drain(4);

        // Start with stop in the same cycle, stop three cycles later.
        rif.io_result_ready = 1'b1;
        measure(3, 8'h01, 4'd1, 1'b0, 1'b1, 1'b0);
        repeat (2) step();

        // Reset while counting (counter at 2) with a coincident stop.
        arm = 1'b1; step(); arm = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        step();
        rst = 1'b1; stop = 1'b1; taps = 8'hFF;
        step();
        rst = 1'b0; stop = 1'b0;
        exp_ovf = 1'b0;
        armed = 1'b0;
        @(negedge clk);
        check_reset_outputs("midreset");
        step();
        step();

        // Tap decode corner cases.
        measure(4, 8'h0B, FINE_0B, 1'b0, 1'b0, 1'b0);
        measure(6, 8'hFF, 4'd8,    1'b0, 1'b0, 1'b0);
        measure(2, 8'h00, 4'd0,    1'b0, 1'b0, 1'b0);
        repeat (2) step();

        // Random traffic with a randomly stalling consumer.
        rand_rdy = 1'b1;
        for (int i = 0; i < 25; i++) begin
            t = ($urandom_range(0, 1) != 0) ? 8'($urandom) : 8'((1 << $urandom_range(0, 8)) - 1);
            measure($urandom_range(1, TMO + 4), t, ref_fine(t), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
            repeat ($urandom_range(0, 2)) step();
        end
        rand_rdy = 1'b0;
        drain(-1);
        step();
        @(negedge clk);
        check("final_empty", sb.size(), 0);
        check("final_valid", {31'd0, rif.io_result_valid}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
